// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequencer.
// Holds the FSM state encoding, memory geometry and the LFSR step function.
package simon_pkg;

    localparam int ADDR_W    = 4;
    localparam int NUM_W     = 2;
    localparam int MEM_DEPTH = 10;

    typedef enum logic [3:0] {
        IDLE,
        APPEND,
        PLAY_RD,
        PLAY_LAT,
        PLAY_SHOW,
        PLAY_GAP,
        INPUT,
        CHK_RD,
        CHK_CMP,
        WIN,
        LOSE
    } state_t;

    // Fibonacci LFSR with taps 8,6,5,4: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit LFSR.
// It steps on every clock and exposes only the two bits used as the next sequence value.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic             clock,
    input  logic             reset,
    output logic [NUM_W-1:0] num
);

    logic [7:0] q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

    assign num = q[NUM_W-1:0];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer.
// It appends random values, plays the sequence back, checks player presses, and is the sole master of the sequence memory.
module simon_seq_ctrl
    import simon_pkg::*;
#(
    parameter int         MAX_LEN     = 10,
    parameter int         SHOW_CYCLES = 2**24,
    parameter int         GAP_CYCLES  = 2**22,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              btn_valid,
    input  logic [NUM_W-1:0]  btn_num,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rw,
    output logic [NUM_W-1:0]  mem_in_num,
    input  logic [NUM_W-1:0]  mem_out_num,
    output logic              show_valid,
    output logic [NUM_W-1:0]  show_num,
    output logic              await_input,
    output logic [ADDR_W-1:0] level,
    output logic              win,
    output logic              lose
);

    localparam int MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  LEN_MAX   = ADDR_W'(MAX_LEN);

    state_t             state;
    logic [ADDR_W-1:0]  len;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  last;
    logic [TIMER_W-1:0] timer;
    logic [NUM_W-1:0]   guess;
    logic [NUM_W-1:0]   rand_num;

    simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .num   (rand_num)
    );

    assign last = len - 1'b1;

    // One timer is shared by the show and gap phases since they never overlap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            idx      <= '0;
            timer    <= '0;
            guess    <= '0;
            show_num <= '0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        len   <= '0;
                        idx   <= '0;
                        state <= APPEND;
                    end
                end
                APPEND: begin
                    len   <= len + 1'b1;
                    idx   <= '0;
                    state <= PLAY_RD;
                end
                PLAY_RD: state <= PLAY_LAT;
                PLAY_LAT: begin
                    show_num <= mem_out_num;
                    timer    <= SHOW_LOAD;
                    state    <= PLAY_SHOW;
                end
                PLAY_SHOW: begin
                    if (timer == '0) begin
                        timer <= GAP_LOAD;
                        state <= PLAY_GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PLAY_GAP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (idx == last) begin
                        idx   <= '0;
                        state <= INPUT;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= PLAY_RD;
                    end
                end
                INPUT: begin
                    if (btn_valid) begin
                        guess <= btn_num;
                        state <= CHK_RD;
                    end
                end
                CHK_RD: state <= CHK_CMP;
                CHK_CMP: begin
                    if (guess != mem_out_num) begin
                        state <= LOSE;
                    end else if (idx != last) begin
                        idx   <= idx + 1'b1;
                        state <= INPUT;
                    end else if (len == LEN_MAX) begin
                        state <= WIN;
                    end else begin
                        state <= APPEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address is driven only where memory is accessed; parked at 0 elsewhere.
    always_comb begin
        mem_address = '0;
        case (state)
            APPEND:                                    mem_address = len;
            PLAY_RD, PLAY_LAT, INPUT, CHK_RD, CHK_CMP: mem_address = idx;
            default:                                   mem_address = '0;
        endcase
    end

    assign mem_rw      = (state == APPEND);
    assign mem_in_num  = (state == APPEND) ? rand_num : '0;
    assign show_valid  = (state == PLAY_SHOW);
    assign await_input = (state == INPUT);
    assign level       = len;
    assign win         = (state == WIN);
    assign lose        = (state == LOSE);

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Self-checking bench for simon_seq_ctrl with a behavioural sequence memory.
// A scripted game model predicts every output cycle by cycle from the game rules.
module tb_simon_seq_ctrl;

    localparam int         MAX_LEN = 3;
    localparam int         SHOW    = 2;
    localparam int         GAP     = 1;
    localparam logic [7:0] SEED    = 8'hA5;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_num;
    logic [3:0] mem_address;
    logic       mem_rw;
    logic [1:0] mem_in_num;
    logic [1:0] mem_out_num;
    logic       show_valid;
    logic [1:0] show_num;
    logic       await_input;
    logic [3:0] level;
    logic       win;
    logic       lose;

    always #5 clock = ~clock;

    simon_seq_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .SHOW_CYCLES (SHOW),
        .GAP_CYCLES  (GAP),
        .LFSR_SEED   (SEED)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .btn_valid   (btn_valid),
        .btn_num     (btn_num),
        .mem_address (mem_address),
        .mem_rw      (mem_rw),
        .mem_in_num  (mem_in_num),
        .mem_out_num (mem_out_num),
        .show_valid  (show_valid),
        .show_num    (show_num),
        .await_input (await_input),
        .level       (level),
        .win         (win),
        .lose        (lose)
    );

    // Sequence memory with a registered read port.
    logic [1:0] mem_arr [0:9];
    always @(posedge clock) begin
        if (mem_rw && mem_address < 4'd10) mem_arr[mem_address] <= mem_in_num;
        mem_out_num <= mem_arr[mem_address];
    end

    int         vectors = 0;
    int         miscompares = 0;
    bit         chk_en = 1'b0;
    logic [7:0] m_lfsr;
    logic [1:0] m_seq [0:9];
    int         m_len = 0;

    logic       e_rw, e_sv, e_aw, e_win, e_lose;
    logic [3:0] e_addr, e_lvl;
    logic [1:0] e_in, e_sn;
    bit         c_addr, c_in, c_sn;

    function automatic logic [7:0] model_step(input logic [7:0] q);
        logic fb;
        fb = ^(q & 8'b1011_1000);
        return {q[6:0], fb};
    endfunction

    task automatic check_output(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Every cycle once checking is enabled, compare against the expected outputs.
    always @(negedge clock) begin
        if (chk_en) begin
            check_output("mem_rw", mem_rw, e_rw);
            if (c_addr) check_output("mem_address", mem_address, e_addr);
            if (c_in || e_rw) check_output("mem_in_num", mem_in_num, e_in);
            check_output("show_valid", show_valid, e_sv);
            if (c_sn) check_output("show_num", show_num, e_sn);
            check_output("await_input", await_input, e_aw);
            check_output("level", level, e_lvl);
            check_output("win", win, e_win);
            check_output("lose", lose, e_lose);
        end
    end

    task automatic exp_default();
        e_rw = 1'b0; c_addr = 1'b0; e_addr = 4'd0; c_in = 1'b0; e_in = 2'd0;
        e_sv = 1'b0; c_sn = 1'b0; e_sn = 2'd0; e_aw = 1'b0;
        e_lvl = m_len[3:0]; e_win = 1'b0; e_lose = 1'b0;
    endtask

    task automatic exp_reset();
        exp_default();
        c_addr = 1'b1;
        c_in   = 1'b1;
        c_sn   = 1'b1;
    endtask

    // Advance one cycle, update the LFSR model and drop any one-cycle pulses.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            m_lfsr = SEED;
            m_len  = 0;
        end else begin
            m_lfsr = model_step(m_lfsr);
        end
        #1;
        start     = 1'b0;
        btn_valid = 1'b0;
        exp_default();
    endtask

    task automatic noise(input bit en);
        if (en) begin
            btn_valid = 1'b1;
            btn_num   = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic do_append();
        tick();
        e_rw   = 1'b1;
        c_addr = 1'b1;
        e_addr = m_len[3:0];
        c_in   = 1'b1;
        e_in   = m_lfsr[1:0];
        m_seq[m_len] = m_lfsr[1:0];
        m_len++;
    endtask

    task automatic do_playback(input bit with_noise);
        for (int i = 0; i < m_len; i++) begin
            tick();
            c_addr = 1'b1;
            e_addr = 4'(i);
            noise(with_noise);
            tick();
            noise(with_noise);
            for (int s = 0; s < SHOW; s++) begin
                tick();
                e_sv = 1'b1;
                c_sn = 1'b1;
                e_sn = m_seq[i];
                noise(with_noise);
            end
            for (int g = 0; g < GAP; g++) begin
                tick();
                noise(with_noise);
            end
        end
    endtask

    // INPUT cycle with the press, then CHK_RD and CHK_CMP.
    task automatic press(input logic [1:0] val, input int idx);
        tick();
        e_aw      = 1'b1;
        c_addr    = 1'b1;
        e_addr    = 4'(idx);
        btn_valid = 1'b1;
        btn_num   = val;
        tick();
        c_addr = 1'b1;
        e_addr = 4'(idx);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_num   = 2'd0;

        tick();
        exp_reset();
        chk_en = 1'b1;
        tick();
        exp_reset();

        // First append after reset: LFSR A5 -> 4A, so the written value is 2.
        reset = 1'b0;
        start = 1'b1;
        do_append();
        check_output("first_in_num", mem_in_num, 8'h2);
        check_output("model_lfsr", m_lfsr, 8'h4A);

        // Reset in the middle of the show phase.
        tick();
        c_addr = 1'b1;
        e_addr = 4'd0;
        tick();
        tick();
        e_sv  = 1'b1;
        c_sn  = 1'b1;
        e_sn  = m_seq[0];
        reset = 1'b1;
        tick();
        exp_reset();
        check_output("rst_level", level, 8'h0);

        reset = 1'b0;
        start = 1'b1;
        do_append();
        check_output("restart_rw", mem_rw, 8'h1);
        check_output("restart_addr", mem_address, 8'h0);
        check_output("restart_in_num", mem_in_num, 8'h2);

        // Round 1 with button noise during playback, then a correct press.
        do_playback(1'b1);
        press(m_seq[0], 0);
        do_append();
        check_output("round2_addr", mem_address, 8'h1);

        // Round 2: start during INPUT is ignored, then a wrong press at idx 1.
        do_playback(1'b1);
        tick();
        e_aw   = 1'b1;
        c_addr = 1'b1;
        e_addr = 4'd0;
        start  = 1'b1;
        press(m_seq[0], 0);
        press(m_seq[1] ^ 2'b01, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            e_lose    = 1'b1;
            btn_valid = 1'b1;
            btn_num   = m_seq[0];
        end
        check_output("lose_flag", lose, 8'h1);
        check_output("lose_level", level, 8'h2);

        // New game from LOSE, played through to a win.
        start = 1'b1;
        m_len = 0;
        do_append();
        for (int r = 0; r < MAX_LEN; r++) begin
            do_playback(1'b0);
            for (int i = 0; i < m_len; i++) press(m_seq[i], i);
            if (m_len < MAX_LEN) do_append();
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            e_win     = 1'b1;
            btn_valid = 1'b1;
        end
        check_output("win_flag", win, 8'h1);
        check_output("win_level", level, 8'h3);

        // Start from WIN begins a fresh game at address 0.
        start = 1'b1;
        m_len = 0;
        do_append();
        check_output("newgame_addr", mem_address, 8'h0);
        check_output("newgame_rw", mem_rw, 8'h1);
        tick();
        c_addr = 1'b1;
        e_addr = 4'd0;
        check_output("newgame_level", level, 8'h1);

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
